alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Datapath/responder end of the button-driven ALU control path.
- Consumes the 4-bit one-hot `control` word from the ALU controller FSM. Captures two operands on load strobes and executes ADD/SUB/MUL/MOD3.
- Presents a held result with a one-cycle `result_valid` pulse.
- MUL and MOD3 are multi-cycle (serial); ADD/SUB complete in one cycle.

Parameters:
- W, 4, operand width in bits (W >= 2).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- control  in  4  one-hot op select: 0001 ADD, 0010 SUB, 0100 MUL, 1000 MOD3, 0000 none
- operand_in  in  W  operand data bus
- load_a  in  1  capture operand_in into A at clk edge
- load_b  in  1  capture operand_in into B at clk edge
- result  out  2W  last completed result, held until next completion
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high while in EXEC
- err  out  1  high while last sampled control was illegal (nonzero, not one-hot)

Behaviour:
- Reset (reset=0): A=0, B=0, ctrl_q=0000, state=IDLE, result=0, result_valid=0, busy=0, err=0. Applies immediately; any operation in flight is discarded.
- Registers:
  - A, B update on their load strobes in any state.
  - ctrl_q holds the last sampled legal control value.
- Start condition at an edge: control is legal one-hot and control != ctrl_q. On start:
  - ctrl_q <= control.
  - Snapshot A, B into working registers; the running op uses the snapshot.
  - Same-edge load: the snapshot takes the pre-load values of A/B.
- control == 0000 sets ctrl_q = 0000, so re-selecting the same op recomputes with the current A/B.
- Illegal control (nonzero, not one-hot): err <= 1, no start, ctrl_q unchanged, result held. If in EXEC, abort to IDLE without result_valid. err clears at the first edge sampling a legal value (including 0000).
- States:
  - IDLE: start with ADD/SUB -> result written at that edge, result_valid=1 next cycle, stay IDLE. Start with MUL/MOD3 -> EXEC, busy=1, cnt=0.
  - EXEC: one iteration per cycle. After W iterations, result is written and state goes to DONE.
  - DONE: result_valid=1, busy=0. Next edge -> IDLE, where a start is allowed again.
- Latency from start edge N:
  - ADD/SUB: result_valid high in cycle N+1.
  - MUL/MOD3: result_valid high in cycle N+W+1.
- Control change to another legal op during EXEC: abort the current op (no result_valid), restart with the new op at that edge. Abort-and-restart also applies in DONE.
- Arithmetic (unsigned operands):
  - ADD: zero-extended (W+1)-bit sum.
  - SUB: (A-B) as 2W-bit two's complement, wrapping (e.g. 3-5 at W=4 -> 8'hFE).
  - MUL: full 2W-bit product via shift-add, LSB of multiplier first.
  - MOD3: A mod 3, MSB-first remainder recursion r <= (2r + bit) mod 3, r in {0,1,2}; result zero-extended.
- result_valid never asserts twice for one start. busy and result_valid are never high together.

Optional Feature:
- Macro ALU_MUL_FAST_EN.
- Defined: MUL is a single-cycle combinational product with the same timing as ADD/SUB; no EXEC entry for MUL, and busy stays 0 for MUL.
- Undefined: W-cycle serial shift-add as above.
- MOD3 is unaffected in both cases.

Decomposition:
- Shared package alu_pkg:
  - Op codes CTRL_ADD=4'b0001, CTRL_SUB=4'b0010, CTRL_MUL=4'b0100, CTRL_MOD3=4'b1000, CTRL_NONE=4'b0000.
  - State encoding IDLE/EXEC/DONE.
  - Legal one-hot check function.
- The controller FSM uses the same op-code constants.
- Sub-module alu_mul_seq:
  - Serial shift-add multiplier with start/abort/done.
  - Instantiated only when ALU_MUL_FAST_EN is undefined.
- MOD3 recursion and control decode stay in alu_exec.

Test Plan:
- Reset mid-operation: start MUL, pull reset low mid-EXEC -> all outputs 0 immediately. After release, re-selecting MUL restarts from scratch with A=B=0 (A, B also reset to 0).
- W=4, A=9, B=5:
  - control 0001 -> result=14 with result_valid 1 cycle later.
  - Then control 0010 -> result=4.
  - Then 0000, 0010 again -> recompute result=4, a second pulse.
- A=3, B=5, control 0010 -> result=8'hFE.
- A=9, B=5, control 0100 -> busy for 4 cycles, result=45 with result_valid exactly once. With ALU_MUL_FAST_EN: result=45 after 1 cycle, busy never high.
- A=14, control 1000 -> result=2 after W cycles. A=15 -> 0. A=13 -> 1.
- During MUL EXEC:
  - control 0011 -> err=1, abort, no result_valid, result unchanged.
  - Then control 0001 -> err=0, ADD result next cycle.
  - During a separate MUL run, switching to 1000 -> abort and restart as MOD3.
  - load_a during EXEC does not alter the running result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and control-word legality helpers for the ALU path.
package alu_pkg;

    localparam logic [3:0] CTRL_NONE = 4'b0000;
    localparam logic [3:0] CTRL_ADD  = 4'b0001;
    localparam logic [3:0] CTRL_SUB  = 4'b0010;
    localparam logic [3:0] CTRL_MUL  = 4'b0100;
    localparam logic [3:0] CTRL_MOD3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [3:0] c);
        return (c != 4'b0000) && ((c & (c - 4'd1)) == 4'b0000);
    endfunction

    // All-zero is legal: it deselects the op so the same op can be re-run.
    function automatic logic is_legal(input logic [3:0] c);
        return (c == CTRL_NONE) || is_onehot(c);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Serial shift-add multiplier, one multiplier bit per cycle, LSB first.
// done and product are combinational during the final iteration so the caller can latch them at that edge.
module alu_mul_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   addend;

    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        product = acc + addend;
        done    = running && (cnt == LAST);
    end

    // start wins over abort so a restart on the same edge reloads cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= {{W{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU datapath responder: operand capture, one-hot control decode, ADD/SUB single-cycle, MUL/MOD3 serial.
// Define ALU_MUL_FAST_EN to make MUL a single-cycle combinational product.
module alu_exec #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       control,
    input  logic [W-1:0]     operand_in,
    input  logic             load_a,
    input  logic             load_b,
    output logic [2*W-1:0]   result,
    output logic             result_valid,
    output logic             busy,
    output logic             err
);

    import alu_pkg::*;

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [3:0]      ctrl_q;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    mod_bits;
    logic [1:0]      mod_r;
    logic            run_mod3;

    logic            illegal;
    logic            start;
    logic            start_long;
    logic [W:0]      sum_w;
    logic [2*W-1:0]  quick_result;
    logic [2:0]      mod_t;
    logic [1:0]      mod_next;
    logic [2*W-1:0]  mod_ext;
    logic            exec_last;
    logic [2*W-1:0]  long_result;

    always_comb begin
        illegal  = !is_legal(control);
        start    = is_onehot(control) && (control != ctrl_q);
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        mod_t    = {mod_r, 1'b0} + {2'b00, mod_bits[W-1]};
        mod_next = (mod_t >= 3'd3) ? 2'(mod_t - 3'd3) : mod_t[1:0];
        mod_ext  = {{(2*W-2){1'b0}}, mod_next};
    end

`ifdef ALU_MUL_FAST_EN
    always_comb begin
        start_long   = (control == CTRL_MOD3);
        quick_result = '0;
        case (control)
            CTRL_ADD: quick_result = {{(W-1){1'b0}}, sum_w};
            CTRL_SUB: quick_result = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
            CTRL_MUL: quick_result = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
            default:  quick_result = '0;
        endcase
        exec_last   = run_mod3 && (cnt == LAST);
        long_result = mod_ext;
    end
`else
    logic            mul_done;
    logic [2*W-1:0]  mul_product;

    alu_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start && (control == CTRL_MUL)),
        .abort   (illegal || start),
        .a       (a_q),
        .b       (b_q),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        start_long   = (control == CTRL_MOD3) || (control == CTRL_MUL);
        quick_result = '0;
        case (control)
            CTRL_ADD: quick_result = {{(W-1){1'b0}}, sum_w};
            CTRL_SUB: quick_result = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
            default:  quick_result = '0;
        endcase
        exec_last   = run_mod3 ? (cnt == LAST) : mul_done;
        long_result = run_mod3 ? mod_ext : mul_product;
    end
`endif

    // Illegal control aborts, a new legal op restarts from any state, otherwise the FSM advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= CTRL_NONE;
            state        <= IDLE;
            cnt          <= '0;
            mod_bits     <= '0;
            mod_r        <= '0;
            run_mod3     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (load_a) begin
                a_q <= operand_in;
            end
            if (load_b) begin
                b_q <= operand_in;
            end
            if (illegal) begin
                err   <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                err <= 1'b0;
                if (control == CTRL_NONE) begin
                    ctrl_q <= CTRL_NONE;
                end
                if (start) begin
                    ctrl_q <= control;
                    if (start_long) begin
                        state    <= EXEC;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        mod_bits <= a_q;
                        mod_r    <= 2'd0;
                        run_mod3 <= (control == CTRL_MOD3);
                    end else begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result       <= quick_result;
                        result_valid <= 1'b1;
                    end
                end else begin
                    case (state)
                        EXEC: begin
                            mod_bits <= mod_bits << 1;
                            mod_r    <= mod_next;
                            cnt      <= cnt + 1'b1;
                            if (exec_last) begin
                                state        <= DONE;
                                busy         <= 1'b0;
                                result       <= long_result;
                                result_valid <= 1'b1;
                            end
                        end
                        DONE:    state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_alu_exec;

    localparam int W = 4;
    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_MOD3 = 4'b1000;
`ifdef ALU_MUL_FAST_EN
    localparam logic [3:0] LONG_OP    = OP_MOD3;
    localparam logic [3:0] SWITCH_OP  = OP_MUL;
    localparam int         SWITCH_LAT = 1;
`else
    localparam logic [3:0] LONG_OP    = OP_MUL;
    localparam logic [3:0] SWITCH_OP  = OP_MOD3;
    localparam int         SWITCH_LAT = W + 1;
`endif
    localparam int BUDGET = 4 * W + 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       control = OP_NONE;
    logic [W-1:0]     operand_in = '0;
    logic             load_a = 1'b0;
    logic             load_b = 1'b0;
    logic [2*W-1:0]   result;
    logic             result_valid;
    logic             busy;
    logic             err;

    int               vectors = 0;
    int               miscompares = 0;
    logic [W-1:0]     model_a = '0;
    logic [W-1:0]     model_b = '0;
    logic [3:0]       model_ctrl = OP_NONE;
    logic [2*W-1:0]   model_result = '0;

    alu_exec #(.W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .control      (control),
        .operand_in   (operand_in),
        .load_a       (load_a),
        .load_b       (load_b),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_op(input logic [3:0] op, input int a, input int b);
        int r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_MOD3: r = a % 3;
            default: r = 0;
        endcase
        return r[2*W-1:0];
    endfunction

    // Edges from presenting the op until result_valid is seen.
    function automatic int exp_lat(input logic [3:0] op);
        if (op == OP_MOD3) return W + 1;
`ifdef ALU_MUL_FAST_EN
        return 1;
`else
        return (op == OP_MUL) ? W + 1 : 1;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        operand_in = a;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        operand_in = b;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        model_a = a;
        model_b = b;
    endtask

    task automatic prep(input logic [3:0] op);
        if (model_ctrl == op) begin
            control = OP_NONE;
            tick();
            model_ctrl = OP_NONE;
        end
    endtask

    // Present op (optionally loading a new A on the same edge) and check value, latency, busy span and single pulse.
    task automatic apply_stimulus(input logic [3:0] op, input string tag, input bit same_load, input logic [W-1:0] new_a);
        logic [2*W-1:0] expv;
        logic [2*W-1:0] cap;
        int lat, edges, busy_cnt;
        bit got;
        prep(op);
        expv = ref_op(op, int'(model_a), int'(model_b));
        lat = exp_lat(op);
        control = op;
        if (same_load) begin
            operand_in = new_a;
            load_a = 1'b1;
        end
        edges = 0;
        busy_cnt = 0;
        got = 1'b0;
        cap = '0;
        while (!got && edges < BUDGET) begin
            tick();
            load_a = 1'b0;
            edges++;
            if (result_valid === 1'b1) begin
                got = 1'b1;
                cap = result;
                check_output({tag, "_busy_with_valid"}, 32'(busy), 32'd0);
            end else if (busy === 1'b1) begin
                busy_cnt++;
            end
        end
        if (same_load) model_a = new_a;
        check_output({tag, "_seen"}, 32'(got), 32'd1);
        check_output({tag, "_latency"}, 32'(edges), 32'(lat));
        check_output({tag, "_result"}, 32'(cap), 32'(expv));
        check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
        tick();
        check_output({tag, "_single_pulse"}, 32'(result_valid), 32'd0);
        check_output({tag, "_held"}, 32'(result), 32'(expv));
        model_ctrl = op;
        model_result = expv;
    endtask

    initial begin
        logic [2*W-1:0] expv;
        logic [2*W-1:0] cap;
        int edges, got_at, vcount;

        // Reset values
        tick();
        tick();
        check_output("rst_result", 32'(result), 32'd0);
        check_output("rst_valid", 32'(result_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        tick();

        // Reset in the middle of a long operation
        load_ops(4'd9, 4'd5);
        control = LONG_OP;
        tick();
        tick();
        check_output("midrst_busy_before", 32'(busy), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check_output("midrst_result", 32'(result), 32'd0);
        check_output("midrst_valid", 32'(result_valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_err", 32'(err), 32'd0);
        control = OP_NONE;
        tick();
        reset = 1'b1;
        model_a = '0;
        model_b = '0;
        model_ctrl = OP_NONE;
        model_result = '0;
        apply_stimulus(LONG_OP, "after_reset", 1'b0, '0);

        // Directed arithmetic
        load_ops(4'd9, 4'd5);
        apply_stimulus(OP_ADD, "add_9_5", 1'b0, '0);
        apply_stimulus(OP_SUB, "sub_9_5", 1'b0, '0);
        apply_stimulus(OP_SUB, "sub_again", 1'b0, '0);
        load_ops(4'd3, 4'd5);
        apply_stimulus(OP_SUB, "sub_wrap", 1'b0, '0);
        load_ops(4'd9, 4'd5);
        apply_stimulus(OP_MUL, "mul_9_5", 1'b0, '0);
        load_ops(4'd14, 4'd0);
        apply_stimulus(OP_MOD3, "mod3_14", 1'b0, '0);
        load_ops(4'd15, 4'd0);
        apply_stimulus(OP_MOD3, "mod3_15", 1'b0, '0);
        load_ops(4'd13, 4'd0);
        apply_stimulus(OP_MOD3, "mod3_13", 1'b0, '0);

        // Illegal control during a long op aborts it, then ADD recovers
        load_ops(4'd9, 4'd5);
        prep(LONG_OP);
        control = LONG_OP;
        tick();
        check_output("illegal_busy_start", 32'(busy), 32'd1);
        tick();
        control = 4'b0011;
        tick();
        check_output("illegal_err", 32'(err), 32'd1);
        check_output("illegal_busy", 32'(busy), 32'd0);
        check_output("illegal_valid", 32'(result_valid), 32'd0);
        check_output("illegal_result_held", 32'(result), 32'(model_result));
        vcount = 0;
        for (int i = 0; i < W + 1; i++) begin
            tick();
            if (result_valid === 1'b1) vcount++;
        end
        check_output("illegal_no_pulse", 32'(vcount), 32'd0);
        check_output("illegal_err_holds", 32'(err), 32'd1);
        control = OP_ADD;
        tick();
        check_output("recover_err", 32'(err), 32'd0);
        check_output("recover_valid", 32'(result_valid), 32'd1);
        check_output("recover_result", 32'(result), 32'(ref_op(OP_ADD, 9, 5)));
        tick();
        model_ctrl = OP_ADD;
        model_result = ref_op(OP_ADD, 9, 5);

        // Switch op mid-run, then load A while the new op runs on its snapshot
        prep(LONG_OP);
        control = LONG_OP;
        tick();
        tick();
        check_output("switch_no_early_valid", 32'(result_valid), 32'd0);
        expv = ref_op(SWITCH_OP, int'(model_a), int'(model_b));
        control = SWITCH_OP;
        tick();
        edges = 1;
        got_at = 0;
        cap = '0;
        if (result_valid === 1'b1) begin
            got_at = 1;
            cap = result;
        end
        operand_in = 4'd7;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        edges = 2;
        if (got_at == 0 && result_valid === 1'b1) begin
            got_at = 2;
            cap = result;
        end
        while (got_at == 0 && edges < BUDGET) begin
            tick();
            edges++;
            if (result_valid === 1'b1) begin
                got_at = edges;
                cap = result;
            end
        end
        check_output("switch_latency", 32'(got_at), 32'(SWITCH_LAT));
        check_output("switch_result", 32'(cap), 32'(expv));
        tick();
        check_output("switch_single_pulse", 32'(result_valid), 32'd0);
        model_a = 4'd7;
        model_ctrl = SWITCH_OP;
        model_result = expv;

        // Randomized ops, every other one loading a new A on the start edge
        for (int i = 0; i < 24; i++) begin
            load_ops(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
            apply_stimulus(4'b0001 << $urandom_range(0, 3), $sformatf("rand%0d", i), i[0],
                           W'($urandom_range(0, (1 << W) - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
